// File: rtl/seq_det_pkg.sv
// Shared constants and config types for the ASCII sequence detector.
// lane_cfg_t describes one lane's programming at the default geometry.
package seq_det_pkg;

    localparam int DEF_CHAR_W  = 8;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_NUM_PAT = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);

    localparam logic [DEF_CHAR_W-1:0] CH_A = 8'h41;
    localparam logic [DEF_CHAR_W-1:0] CH_B = 8'h42;
    localparam logic [DEF_CHAR_W-1:0] CH_K = 8'h4B;
    localparam logic [DEF_CHAR_W-1:0] CH_M = 8'h4D;
    localparam logic [DEF_CHAR_W-1:0] CH_N = 8'h4E;
    localparam logic [DEF_CHAR_W-1:0] CH_Z = 8'h5A;

    typedef struct packed {
        logic [DEF_MAX_LEN-1:0][DEF_CHAR_W-1:0] pat;
        logic [DEF_LEN_W-1:0]                   len;
        logic                                   en;
    } lane_cfg_t;

endpackage

// File: rtl/seq_match_lane.sv
// One pattern lane: holds its config, compares the shared history plus the
// incoming char against its pattern, and keeps hit, sticky and counter state.
module seq_match_lane #(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [CHAR_W-1:0]                in_char,
    input  logic [MAX_LEN-2:0][CHAR_W-1:0]   hist,
    input  logic [LEN_W-1:0]                 fill,
    input  logic                             cfg_we,
    input  logic [MAX_LEN*CHAR_W-1:0]        cfg_pat,
    input  logic [LEN_W-1:0]                 cfg_len,
    input  logic                             cfg_en,
    input  logic                             clr_sticky,
    output logic                             hit,
    output logic                             sticky,
    output logic [CNT_W-1:0]                 cnt
);

    logic [MAX_LEN-1:0][CHAR_W-1:0] pat;
    logic [LEN_W-1:0]               len;
    logic                           en;
    logic                           match;

    // Last pattern char meets in_char; pat[len-2-i] meets hist[i] for the rest.
    always_comb begin
        match = in_valid && en && (len != '0) && (int'(len) <= MAX_LEN)
                && (int'(fill) + 1 >= int'(len));
        for (int j = 0; j < MAX_LEN; j++)
            if (j == int'(len) - 1 && pat[j] != in_char)
                match = 1'b0;
        for (int i = 0; i < MAX_LEN - 1; i++)
            for (int j = 0; j < MAX_LEN - 1; j++)
                if (i + j == int'(len) - 2 && hist[i] != pat[j])
                    match = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat <= '0;
            len <= '0;
            en  <= 1'b0;
        end else if (cfg_we) begin
            pat <= cfg_pat;
            len <= cfg_len;
            en  <= cfg_en;
        end
    end

    // The hit from the old config still fires on a config-write edge,
    // but the write's clear beats the sticky set and the counter increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit    <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            hit <= match;
            if (cfg_we) begin
                sticky <= 1'b0;
                cnt    <= '0;
            end else begin
                if (match)
                    sticky <= 1'b1;
                else if (clr_sticky)
                    sticky <= 1'b0;
                if (match && cnt != '1)
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ascii_seq_detector.sv
// Matches an ASCII char stream against NUM_PAT programmable patterns in
// parallel; owns the shared history/fill registers and the hit_any OR.
module ascii_seq_detector
    import seq_det_pkg::*;
#(
    parameter int  CHAR_W  = DEF_CHAR_W,
    parameter int  MAX_LEN = DEF_MAX_LEN,
    parameter int  NUM_PAT = DEF_NUM_PAT,
    parameter int  CNT_W   = DEF_CNT_W,
    localparam int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [CHAR_W-1:0]          in_char,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic [MAX_LEN*CHAR_W-1:0]  cfg_pat,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       cfg_en,
    input  logic                       clr_sticky,
    output logic [NUM_PAT-1:0]         hit,
    output logic [NUM_PAT-1:0]         hit_sticky,
    output logic                       hit_any,
    output logic [NUM_PAT*CNT_W-1:0]   hit_cnt
);

    logic [MAX_LEN-2:0][CHAR_W-1:0] hist;
    logic [LEN_W-1:0]               fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist[0] <= in_char;
            for (int i = 1; i < MAX_LEN - 1; i++)
                hist[i] <= hist[i-1];
            if (fill != LEN_W'(MAX_LEN))
                fill <= fill + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_PAT; k++) begin : g_lane
        seq_match_lane #(
            .CHAR_W  (CHAR_W),
            .MAX_LEN (MAX_LEN),
            .CNT_W   (CNT_W),
            .LEN_W   (LEN_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_char    (in_char),
            .hist       (hist),
            .fill       (fill),
            .cfg_we     (cfg_we && (cfg_idx == IDX_W'(k))),
            .cfg_pat    (cfg_pat),
            .cfg_len    (cfg_len),
            .cfg_en     (cfg_en),
            .clr_sticky (clr_sticky),
            .hit        (hit[k]),
            .sticky     (hit_sticky[k]),
            .cnt        (hit_cnt[k*CNT_W +: CNT_W])
        );
    end

    assign hit_any = |hit;

endmodule
